ping_pong_bank_sched: RTL



---
 rtl/ping_pong_bank_sched.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ping_pong_bank_sched.sv
// Ping-pong scheduler for a two-bank BRAM buffer: producer fills one bank on port A
// while the consumer drains the other on port B, with a read-latency-aligned valid strobe.
module ping_pong_bank_sched #(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  bank0_ena_ctrl,
  output logic                  bank1_ena_ctrl,
  output logic                  bank0_wea_ctrl,
  output logic                  bank1_wea_ctrl,
  output logic [ADDR_WIDTH-1:0] bank0_addra_ctrl,
  output logic [ADDR_WIDTH-1:0] bank1_addra_ctrl,
  output logic                  bank0_enb_ctrl,
  output logic                  bank1_enb_ctrl,
  output logic [ADDR_WIDTH-1:0] bank0_addrb_ctrl,
  output logic [ADDR_WIDTH-1:0] bank1_addrb_ctrl,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  out_bank_sel,
  output logic [1:0]            bank_full
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  bank_state_e           r_bankState [2];
  logic                  r_wrBank;
  logic                  r_rdBank;
  logic [ADDR_WIDTH-1:0] r_wrAddr;
  logic [ADDR_WIDTH-1:0] r_rdAddr;
  logic [RD_LATENCY-1:0] r_pipeValid;
  logic [RD_LATENCY-1:0] r_pipeLast;
  logic [RD_LATENCY-1:0] r_pipeBank;

  logic w_wrOpen;
  logic w_rdAvail;
  logic w_wrFire;
  logic w_rdFire;
  logic w_wrLast;
  logic w_rdLast;

  assign w_wrOpen  = (r_bankState[r_wrBank] == EMPTY) || (r_bankState[r_wrBank] == FILLING);
  assign w_rdAvail = (r_bankState[r_rdBank] == FULL)  || (r_bankState[r_rdBank] == DRAINING);
  assign in_ready  = !rst && w_wrOpen;
  assign w_wrFire  = in_valid && in_ready;
  assign w_rdFire  = out_ready && w_rdAvail;
  assign w_wrLast  = (r_wrAddr == LAST_ADDR);
  assign w_rdLast  = (r_rdAddr == LAST_ADDR);

  // Idle address buses are driven to zero rather than holding the last pointer.
  assign bank0_ena_ctrl   = w_wrFire && !r_wrBank;
  assign bank1_ena_ctrl   = w_wrFire && r_wrBank;
  assign bank0_wea_ctrl   = bank0_ena_ctrl;
  assign bank1_wea_ctrl   = bank1_ena_ctrl;
  assign bank0_addra_ctrl = bank0_ena_ctrl ? r_wrAddr : '0;
  assign bank1_addra_ctrl = bank1_ena_ctrl ? r_wrAddr : '0;
  assign bank0_enb_ctrl   = w_rdFire && !r_rdBank;
  assign bank1_enb_ctrl   = w_rdFire && r_rdBank;
  assign bank0_addrb_ctrl = bank0_enb_ctrl ? r_rdAddr : '0;
  assign bank1_addrb_ctrl = bank1_enb_ctrl ? r_rdAddr : '0;

  assign bank_full[0] = (r_bankState[0] == FULL) || (r_bankState[0] == DRAINING);
  assign bank_full[1] = (r_bankState[1] == FULL) || (r_bankState[1] == DRAINING);

  assign out_valid    = r_pipeValid[RD_LATENCY-1];
  assign out_last     = r_pipeLast[RD_LATENCY-1];
  assign out_bank_sel = r_pipeBank[RD_LATENCY-1];

  // Write and read fires can never target the same bank, so both updates may land together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bankState[0] <= EMPTY;
      r_bankState[1] <= EMPTY;
      r_wrBank       <= 1'b0;
      r_rdBank       <= 1'b0;
      r_wrAddr       <= '0;
      r_rdAddr       <= '0;
      r_pipeValid    <= '0;
      r_pipeLast     <= '0;
      r_pipeBank     <= '0;
    end else begin
      if (w_wrFire) begin
        r_bankState[r_wrBank] <= w_wrLast ? FULL : FILLING;
        if (w_wrLast) begin
          r_wrAddr <= '0;
          r_wrBank <= !r_wrBank;
        end else begin
          r_wrAddr <= r_wrAddr + 1'b1;
        end
      end
      if (w_rdFire) begin
        r_bankState[r_rdBank] <= w_rdLast ? EMPTY : DRAINING;
        if (w_rdLast) begin
          r_rdAddr <= '0;
          r_rdBank <= !r_rdBank;
        end else begin
          r_rdAddr <= r_rdAddr + 1'b1;
        end
      end
      r_pipeValid[0] <= w_rdFire;
      r_pipeLast[0]  <= w_rdFire && w_rdLast;
      r_pipeBank[0]  <= w_rdFire && r_rdBank;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeLast[i]  <= r_pipeLast[i-1];
        r_pipeBank[i]  <= r_pipeBank[i-1];
      end
    end
  end

endmodule
